// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared funct3 codes, strobes and FSM encoding for the LSU
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_e;

  // Loads reject 3, 6 and 7; stores accept only SB/SH/SW.
  function automatic logic funct3_illegal(input logic write, input logic [2:0] f3);
    if (write) return (f3 > 3'd2);
    return (f3 == 3'd3) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and RAM-side bus of the load/store unit
interface load_store_unit_if #(
  parameter int ADDR_W = 10
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // master is the core plus RAM environment, slave is the LSU itself
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wstrb, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wstrb, mem_wdata
  );

endinterface

// File: rtl/load_store_unit_load_align.sv
// rtl/load_store_unit_load_align.sv - selects and extends the loaded byte/half/word
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = word >> {offset, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store stage in front of a sync data RAM
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  load_store_unit_if.slave    bus
);

  lsu_state_e        state_q, state_d;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [1:0]        offset_q;
  logic              accept;
  logic              req_err;

  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       load_data;

  lsu_load_align u_align (
    .word   (bus.mem_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .result (load_data)
  );

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_wdata  = mem_wdata_q;

  always_comb begin
    req_err = funct3_illegal(bus.req_write, bus.req_funct3)
            || ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
            || ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00))
            || ((bus.req_addr >> (ADDR_W + 2)) != 32'd0);
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = 4'b0000;  // strobes live for exactly the ACCESS cycle
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (req_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d    = ST_ACCESS;
            mem_addr_d = bus.req_addr[ADDR_W+1:2];
            if (bus.req_write) begin
              case (bus.req_funct3)
                F3_SB: begin
                  mem_wdata_d = {4{bus.req_wdata[7:0]}};
                  mem_wstrb_d = STRB_B << bus.req_addr[1:0];
                end
                F3_SH: begin
                  mem_wdata_d = {2{bus.req_wdata[15:0]}};
                  mem_wstrb_d = STRB_H << bus.req_addr[1:0];
                end
                default: begin
                  mem_wdata_d = bus.req_wdata;
                  mem_wstrb_d = STRB_W;
                end
              endcase
            end
          end
        end
      end
      ST_ACCESS: begin
        if (write_q) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'd0;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = load_data;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      offset_q     <= 2'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      if (accept) begin
        write_q  <= bus.req_write;
        funct3_q <= bus.req_funct3;
        offset_q <= bus.req_addr[1:0];
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int ADDR_W = 10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [31:0] ram [0:(1<<ADDR_W)-1];

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.mem_wstrb[b]) ram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issues one request at the next negedge and watches six cycles after the accept edge.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata,
                        output logic [31:0] lat, output logic [31:0] rdata, output logic [31:0] err,
                        output logic [31:0] nstrb, output logic [31:0] npulse,
                        output logic [31:0] a1, output logic [31:0] s1, output logic [31:0] d1);
    lat = 0; rdata = 32'hx; err = 32'hx; nstrb = 0; npulse = 0;
    a1 = 0; s1 = 0; d1 = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a1 = 32'(bus.mem_addr);
        s1 = 32'(bus.mem_wstrb);
        d1 = bus.mem_wdata;
      end
      if (bus.mem_wstrb != 4'b0000) nstrb++;
      if (bus.resp_valid) begin
        npulse++;
        if (lat == 0) begin
          lat   = k;
          rdata = bus.resp_rdata;
          err   = 32'(bus.resp_err);
        end
      end
    end
  endtask

  task automatic run(input string tag, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_lat, input logic [31:0] exp_rdata,
                     input logic [31:0] exp_err);
    logic [31:0] lat, rdata, err, nstrb, npulse, a1, s1, d1;
    do_req(wr, f3, addr, wdata, lat, rdata, err, nstrb, npulse, a1, s1, d1);
    check({tag, ".lat"},    lat,    exp_lat);
    check({tag, ".rdata"},  rdata,  exp_rdata);
    check({tag, ".err"},    err,    exp_err);
    check({tag, ".pulses"}, npulse, 32'd1);
    check({tag, ".strbcyc"}, nstrb, (wr && exp_err == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [31:0] lat, rdata, err, nstrb, npulse, a1, s1, d1;
    int ready_k, pulse1, pulse2;
    logic [31:0] bb_rdata;
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = 32'd0;
    ram[1] = 32'h8081F2F3;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    rst = 1'b1;
    #1;
    check("rst.req_ready",  32'(bus.req_ready),  32'd1);
    check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst.resp_err",   32'(bus.resp_err),   32'd0);
    check("rst.resp_rdata", bus.resp_rdata,      32'd0);
    check("rst.mem_addr",   32'(bus.mem_addr),   32'd0);
    check("rst.mem_wstrb",  32'(bus.mem_wstrb),  32'd0);
    check("rst.mem_wdata",  bus.mem_wdata,       32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run("lb7",   1'b0, F3_LB,  32'h7, 32'd0, 32'd3, 32'hFFFFFF80, 32'd0);
    run("lbu4",  1'b0, F3_LBU, 32'h4, 32'd0, 32'd3, 32'h000000F3, 32'd0);
    run("lhu6",  1'b0, F3_LHU, 32'h6, 32'd0, 32'd3, 32'h00008081, 32'd0);
    run("lh4",   1'b0, F3_LH,  32'h4, 32'd0, 32'd3, 32'hFFFFF2F3, 32'd0);

    do_req(1'b1, F3_SB, 32'h5, 32'h123456AA, lat, rdata, err, nstrb, npulse, a1, s1, d1);
    check("sb5.mem_addr",  a1,    32'd1);
    check("sb5.mem_wstrb", s1,    32'h2);
    check("sb5.mem_wdata", d1,    32'hAAAAAAAA);
    check("sb5.lat",       lat,   32'd2);
    check("sb5.err",       err,   32'd0);
    check("sb5.strbcyc",   nstrb, 32'd1);
    run("lw4",   1'b0, F3_LW,  32'h4, 32'd0, 32'd3, 32'h8081AAF3, 32'd0);

    run("sh6",   1'b1, F3_SH,  32'h6, 32'h0000BEEF, 32'd2, 32'd0, 32'd0);
    run("lw4b",  1'b0, F3_LW,  32'h4, 32'd0, 32'd3, 32'hBEEFAAF3, 32'd0);

    run("lw2err",   1'b0, F3_LW, 32'h2,    32'd0, 32'd1, 32'd0, 32'd1);
    run("swrange",  1'b1, F3_SW, 32'h1000, 32'h5, 32'd1, 32'd0, 32'd1);
    run("f3err",    1'b0, 3'd3,  32'h0,    32'd0, 32'd1, 32'd0, 32'd1);
    run("lh1err",   1'b0, F3_LH, 32'h1,    32'd0, 32'd1, 32'd0, 32'd1);
    run("sbf3err",  1'b1, 3'd4,  32'h0,    32'd0, 32'd1, 32'd0, 32'd1);

    // reset asserted while the load is in CAPTURE (second cycle after accept)
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = F3_LW; bus.req_addr = 32'h4;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rstmid.mem_wstrb",  32'(bus.mem_wstrb),  32'd0);
    check("rstmid.mem_addr",   32'(bus.mem_addr),   32'd0);
    check("rstmid.resp_rdata", bus.resp_rdata,      32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid.req_ready", 32'(bus.req_ready), 32'd1);
    npulse = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid) npulse++;
    end
    check("rstmid.nopulse", npulse, 32'd0);
    run("lw4post", 1'b0, F3_LW, 32'h4, 32'd0, 32'd3, 32'hBEEFAAF3, 32'd0);

    // back-to-back with req_valid held high across both requests
    ready_k = 0; pulse1 = 0; pulse2 = 0; bb_rdata = 32'd0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = F3_SW;
    bus.req_addr = 32'h8; bus.req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.req_write = 1'b0; bus.req_funct3 = F3_LW; bus.req_wdata = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.req_ready && ready_k == 0) ready_k = k;
      if (bus.resp_valid) begin
        if (pulse1 == 0) pulse1 = k;
        else if (pulse2 == 0) begin
          pulse2   = k;
          bb_rdata = bus.resp_rdata;
        end
      end
      if (k == 4) bus.req_valid = 1'b0;
    end
    check("b2b.ready_cycle", 32'(ready_k),  32'd3);
    check("b2b.sw_resp",     32'(pulse1),   32'd2);
    check("b2b.lw_resp",     32'(pulse2),   32'd6);
    check("b2b.lw_rdata",    bb_rdata,      32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
